// File: rtl/arb_req_pkg.sv
// rtl/arb_req_pkg.sv - shared state encodings, beat helper and one-hot check for the arbiter requester
package arb_req_pkg;

    // FSM state encodings (2-bit)
    localparam logic [1:0] ARB = 2'd0;
    localparam logic [1:0] OWN = 2'd1;
    localparam logic [1:0] REL = 2'd2;

    typedef enum logic [1:0] {
        ST_ARB = ARB,
        ST_OWN = OWN,
        ST_REL = REL
    } state_t;

    // A job of length field L occupies the bus for L + BEAT_BIAS beats.
    localparam int unsigned BEAT_BIAS = 1;

    // Widest vector the one-hot helper accepts; callers zero-extend.
    localparam int unsigned ONEHOT_MAX_W = 64;

    function automatic logic is_onehot(input logic [ONEHOT_MAX_W-1:0] v);
        return (v != '0) && ((v & (v - ONEHOT_MAX_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/arb_onehot_chk.sv
// rtl/arb_onehot_chk.sv - combinational one-hot and subset check of grant against req
//
// Ports:
//   grant    [WIDTH]  grant vector from the arbiter
//   req      [WIDTH]  request vector currently driven to the arbiter
//   grant_ok          grant is one-hot and only names requesting channels
module arb_onehot_chk
    import arb_req_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] grant,
    input  logic [WIDTH-1:0] req,
    output logic             grant_ok
);

    logic [ONEHOT_MAX_W-1:0] grant_ext;

    assign grant_ext = ONEHOT_MAX_W'(grant);
    assign grant_ok  = is_onehot(grant_ext) && ((grant & req) == grant);

endmodule

// File: rtl/arb_req_ctrl.sv
// rtl/arb_req_ctrl.sv - requester-side controller holding fixed-priority arbiter ownership for a job's beats
//
// Optional feature macro: ARB_REQ_GRANT_CHECK_EN (sticky grant-protocol error flag).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   job_valid/job_ready [W]   per-channel job handshake, one outstanding job per channel
//   job_len [W*LEN_W]         flattened job lengths, channel i at [i*LEN_W +: LEN_W]
//   req [W]                   request vector to the arbiter
//   grant [W]                 one-hot grant from the arbiter
//   bus_owner [W]             one-hot owner while OWN, else 0
//   bus_active                high while OWN
//   done [W]                  one-cycle pulse on the owner channel at release
//   err_grant                 sticky grant-protocol error (0 unless the macro is defined)
module arb_req_ctrl
    import arb_req_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       job_valid,
    input  logic [WIDTH*LEN_W-1:0] job_len,
    output logic [WIDTH-1:0]       job_ready,
    output logic [WIDTH-1:0]       req,
    input  logic [WIDTH-1:0]       grant,
    output logic [WIDTH-1:0]       bus_owner,
    output logic                   bus_active,
    output logic [WIDTH-1:0]       done,
    output logic                   err_grant
);

    state_t                 state;
    logic [WIDTH-1:0]       pend;
    logic [WIDTH-1:0]       owner;
    logic [WIDTH*LEN_W-1:0] lens;
    logic [LEN_W-1:0]       cnt;
    logic [LEN_W-1:0]       sel_len;
    logic [WIDTH-1:0]       accept;
    logic [WIDTH-1:0]       release_mask;
    logic                   grant_ok;

    assign job_ready = ~pend;
    assign accept    = job_valid & ~pend;

    // req comes from state registers only; in OWN it is masked down to the
    // owner so the arbiter keeps granting it regardless of newer requests.
    always_comb begin
        req = '0;
        case (state)
            ST_ARB:  req = pend;
            ST_OWN:  req = owner;
            default: req = '0;
        endcase
    end

    assign bus_active = (state == ST_OWN);
    assign bus_owner  = bus_active ? owner : '0;

    arb_onehot_chk #(
        .WIDTH (WIDTH)
    ) u_chk (
        .grant    (grant),
        .req      (req),
        .grant_ok (grant_ok)
    );

    // Length of the channel named by the (one-hot) grant.
    always_comb begin
        sel_len = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (grant[i]) begin
                sel_len = sel_len | lens[i*LEN_W +: LEN_W];
            end
        end
    end

    // The owner's pending bit drops on the last OWN beat, so that channel can
    // take a new job during REL.
    assign release_mask = ((state == ST_OWN) && (cnt == '0)) ? owner : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ARB;
            pend  <= '0;
            lens  <= '0;
            owner <= '0;
            cnt   <= '0;
            done  <= '0;
        end else begin
            done <= '0;
            pend <= (pend | accept) & ~release_mask;
            for (int i = 0; i < WIDTH; i++) begin
                if (accept[i]) begin
                    lens[i*LEN_W +: LEN_W] <= job_len[i*LEN_W +: LEN_W];
                end
            end
            case (state)
                ST_ARB: begin
                    if ((pend != '0) && grant_ok) begin
                        owner <= grant;
                        cnt   <= sel_len;
                        state <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (cnt == '0) begin
                        done  <= owner;
                        state <= ST_REL;
                    end else begin
                        cnt <= cnt - LEN_W'(1);
                    end
                end
                ST_REL: begin
                    owner <= '0;
                    state <= ST_ARB;
                end
                default: state <= ST_ARB;
            endcase
        end
    end

`ifdef ARB_REQ_GRANT_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_grant <= 1'b0;
        end else if (((state == ST_ARB) && (pend != '0) && (grant != '0) && !grant_ok) ||
                     ((state == ST_OWN) && (grant != owner))) begin
            err_grant <= 1'b1;
        end
    end
`else
    assign err_grant = 1'b0;
`endif

endmodule
